noc_output_port_arbiter: RTL and testbench

//   Wormhole output-port arbiter for one router output. NUM_PORTS input channels contend for one

---
 rtl/noc_output_port_arbiter_pkg.sv | 11 +
 rtl/noc_rr_arbiter.sv | 27 ++
 rtl/noc_output_port_arbiter.sv | 113 +++++++++++
 tb/tb_noc_output_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_output_port_arbiter_pkg.sv
// Shared constants for the wormhole output-port arbiter: flit width, port count
// and the two-state arbitration FSM encoding.
package noc_output_port_arbiter_pkg;

    localparam int NOC_DATA_WIDTH = 32;
    localparam int NOC_NUM_PORTS  = 5;

    localparam logic NOC_ARB_IDLE   = 1'b0;
    localparam logic NOC_ARB_LOCKED = 1'b1;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr,
// wrapping to the lowest requesting index overall when none lie above ptr.
module noc_rr_arbiter #(
    parameter int N = 5
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_pick_src;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i >= int'(ptr));
        end
    end

    assign w_masked   = req & w_mask;
    assign w_pick_src = (|w_masked) ? w_masked : req;
    // x & -x isolates the lowest set bit, giving a one-hot result directly.
    assign gnt        = w_pick_src & (~w_pick_src + N'(1));

endmodule

// File: rtl/noc_output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin grant on a header, held until the
// packet's tail transfers. Flits pass through combinationally from the owner.
module noc_output_port_arbiter
    import noc_output_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = NOC_NUM_PORTS,
    parameter int DATA_WIDTH = NOC_DATA_WIDTH
) (
    input  logic                            noc_clk,
    input  logic                            noc_rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_flit,
    input  logic [NUM_PORTS-1:0]            in_is_header,
    input  logic [NUM_PORTS-1:0]            in_is_tail,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_flit,
    output logic                            out_is_header,
    output logic                            out_is_tail,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            err_orphan,
    output logic                            dbg_state
);

    localparam int PW = $clog2(NUM_PORTS);

    // Handshake: a flit moves on a port or on the link when valid and ready are
    // both high in the same cycle; valid never waits on ready.

    logic                  r_state;
    logic [NUM_PORTS-1:0]  r_grant;
    logic [PW-1:0]         r_rr_ptr;
    logic                  r_err_orphan;

    logic [NUM_PORTS-1:0]  w_req;
    logic [NUM_PORTS-1:0]  w_orphan;
    logic [NUM_PORTS-1:0]  w_arb_gnt;
    logic [PW-1:0]         w_next_ptr;
    logic                  w_tail_xfer;
    logic [DATA_WIDTH-1:0] w_out_flit;
    logic                  w_out_valid;
    logic                  w_out_header;
    logic                  w_out_tail;

    assign w_req    = in_valid & in_is_header;
    assign w_orphan = in_valid & ~in_is_header;

    noc_rr_arbiter #(
        .N (NUM_PORTS)
    ) u_rr (
        .req (w_req),
        .ptr (r_rr_ptr),
        .gnt (w_arb_gnt)
    );

    // AND-OR mux over the one-hot grant; an all-zero grant yields all-zero outputs.
    always_comb begin
        w_out_flit   = '0;
        w_out_valid  = 1'b0;
        w_out_header = 1'b0;
        w_out_tail   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_out_flit   = w_out_flit | (in_flit[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
            w_out_valid  = w_out_valid  | (in_valid[i]     & r_grant[i]);
            w_out_header = w_out_header | (in_is_header[i] & r_grant[i]);
            w_out_tail   = w_out_tail   | (in_is_tail[i]   & r_grant[i]);
        end
    end

    always_comb begin
        w_next_ptr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant[i]) begin
                w_next_ptr = (i == NUM_PORTS - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    assign w_tail_xfer = w_out_valid & out_ready & w_out_tail;

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_state      <= NOC_ARB_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_err_orphan <= 1'b0;
        end else if (r_state == NOC_ARB_IDLE) begin
            if (|w_orphan) begin
                r_err_orphan <= 1'b1;
            end
            if (|w_req) begin
                r_grant <= w_arb_gnt;
                r_state <= NOC_ARB_LOCKED;
            end
        end else if (w_tail_xfer) begin
            // No re-arbitration here: the next owner is picked in the following IDLE cycle.
            r_state  <= NOC_ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
        end
    end

    assign in_ready      = r_grant & {NUM_PORTS{out_ready}};
    assign out_valid     = w_out_valid;
    assign out_flit      = w_out_flit;
    assign out_is_header = w_out_header;
    assign out_is_tail   = w_out_tail;
    assign grant         = r_grant;
    assign err_orphan    = r_err_orphan;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Bench for the output-port arbiter: packet-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_noc_output_port_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;

    logic            noc_clk = 1'b0;
    logic            noc_rst;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_flit;
    logic [N-1:0]    in_is_header;
    logic [N-1:0]    in_is_tail;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_flit;
    logic            out_is_header;
    logic            out_is_tail;
    logic [N-1:0]    grant;
    logic            err_orphan;
    logic            dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            got_cyc_q[$];

    // Model state: owning port (-1 when no packet holds the link), rotation start, sticky error.
    int   m_owner  = -1;
    int   m_ptr    = 0;
    logic m_orphan = 1'b0;

    noc_output_port_arbiter #(
        .NUM_PORTS  (N),
        .DATA_WIDTH (DW)
    ) dut (
        .noc_clk       (noc_clk),
        .noc_rst       (noc_rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flit       (in_flit),
        .in_is_header  (in_is_header),
        .in_is_tail    (in_is_tail),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_flit      (out_flit),
        .out_is_header (out_is_header),
        .out_is_tail   (out_is_tail),
        .grant         (grant),
        .err_orphan    (err_orphan),
        .dbg_state     (dbg_state)
    );

    always #5 noc_clk = ~noc_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic clr();
        in_valid     = '0;
        in_is_header = '0;
        in_is_tail   = '0;
        in_flit      = '0;
    endtask

    task automatic set_port(input int p, input logic v, input logic [DW-1:0] f, input logic h, input logic t);
        in_valid[p]          = v;
        in_flit[p*DW +: DW]  = f;
        in_is_header[p]      = h;
        in_is_tail[p]        = t;
    endtask

    task automatic check_got(input string name);
        int n;
        chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk(name, got_q[i], exp_q[i]);
        end
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    // Reference model and per-cycle compare.
    initial begin : model
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_ready;
        logic          e_v, e_h, e_t;
        logic [DW-1:0] e_f;
        int            p;
        forever begin
            @(negedge noc_clk);
            e_grant = '0;
            e_ready = '0;
            e_v = 1'b0;
            e_h = 1'b0;
            e_t = 1'b0;
            e_f = '0;
            if (m_owner >= 0) begin
                e_grant = N'(1) << m_owner;
                e_v     = in_valid[m_owner];
                e_h     = in_is_header[m_owner];
                e_t     = in_is_tail[m_owner];
                e_f     = in_flit[m_owner*DW +: DW];
                e_ready = out_ready ? e_grant : '0;
            end
            chk("m_grant",     grant,         e_grant);
            chk("m_in_ready",  in_ready,      e_ready);
            chk("m_out_valid", out_valid,     e_v);
            chk("m_out_flit",  out_flit,      e_f);
            chk("m_out_hdr",   out_is_header, e_h);
            chk("m_out_tail",  out_is_tail,   e_t);
            chk("m_orphan",    err_orphan,    m_orphan);
            chk("m_state",     dbg_state,     m_owner >= 0);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                got_q.push_back(out_flit);
                got_cyc_q.push_back(cyc);
            end
            @(posedge noc_clk);
            cyc++;
            if (noc_rst) begin
                m_owner  = -1;
                m_ptr    = 0;
                m_orphan = 1'b0;
            end else if (m_owner < 0) begin
                if ((in_valid & ~in_is_header) != '0) m_orphan = 1'b1;
                for (int k = 0; k < N; k++) begin
                    p = (m_ptr + k) % N;
                    if (m_owner < 0 && in_valid[p] && in_is_header[p]) m_owner = p;
                end
            end else if (in_valid[m_owner] && out_ready && in_is_tail[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    end

    initial begin : stim
        logic [5:0] pat;
        int         idx;
        int         ord[3];
        int         cnt[N];
        int         gp;

        // Reset held three cycles with every port offering a header.
        clr();
        out_ready = 1'b0;
        noc_rst   = 1'b1;
        for (int p = 0; p < N; p++) set_port(p, 1'b1, DW'(32'h10 + p), 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_grant",  grant,      5'b00000);
            chk("rst_ready",  in_ready,   5'b00000);
            chk("rst_valid",  out_valid,  1'b0);
            chk("rst_orphan", err_orphan, 1'b0);
        end
        noc_rst = 1'b0;
        tick();
        chk("rst_first_grant", grant, 5'b00001);
        clr();
        set_port(0, 1'b1, 32'h1F, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        clr();
        chk("rst_release_grant", grant, 5'b00000);
        got_q.delete();
        got_cyc_q.delete();

        // Single four-flit packet from port 2.
        set_port(2, 1'b1, 32'hA0, 1'b1, 1'b0);
        tick();
        chk("single_grant", grant, 5'b00100);
        for (int i = 0; i < 4; i++) begin
            set_port(2, 1'b1, DW'(32'hA0 + i), i == 0, i == 3);
            tick();
        end
        clr();
        chk("single_grant_after", grant, 5'b00000);
        if (got_cyc_q.size() == 4) chk("single_consecutive", 64'(got_cyc_q[3] - got_cyc_q[0]), 64'd3);
        for (int i = 0; i < 4; i++) exp_q.push_back(DW'(32'hA0 + i));
        check_got("single_flits");

        // Backpressure: out_ready follows 1,0,0,1,0,1 once port 3 owns the link.
        set_port(3, 1'b1, 32'h30, 1'b1, 1'b0);
        out_ready = 1'b0;
        tick();
        chk("bp_grant", grant, 5'b01000);
        pat = 6'b101001;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            out_ready = pat[c];
            set_port(3, 1'b1, DW'(32'h30 + idx), idx == 0, idx == 2);
            #1;
            chk("bp_ready3", in_ready[3], pat[c]);
            chk("bp_flit",   out_flit,    DW'(32'h30 + idx));
            tick();
            if (pat[c]) idx++;
        end
        clr();
        chk("bp_grant_after", grant, 5'b00000);
        for (int i = 0; i < 3; i++) exp_q.push_back(DW'(32'h30 + i));
        check_got("bp_flits");

        // Round robin over ports 0,1,4 offering one-flit packets back to back.
        noc_rst = 1'b1;
        tick();
        noc_rst   = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        got_cyc_q.delete();
        ord = '{0, 1, 4};
        for (int p = 0; p < N; p++) cnt[p] = 0;
        for (int k = 0; k < 3; k++) set_port(ord[k], 1'b1, DW'((ord[k] << 8) | 0), 1'b1, 1'b1);
        for (int c = 0; c < 60; c++) begin
            tick();
            if (c % 2 == 0) begin
                gp = ord[(c / 2) % 3];
                chk("rr_grant", grant, N'(1) << gp);
                exp_q.push_back(DW'((gp << 8) | cnt[gp]));
            end else begin
                chk("rr_gap", grant, 5'b00000);
                gp = ord[((c - 1) / 2) % 3];
                cnt[gp]++;
                set_port(gp, 1'b1, DW'((gp << 8) | cnt[gp]), 1'b1, 1'b1);
            end
        end
        clr();
        chk("rr_count0", 64'(cnt[0]), 64'd10);
        chk("rr_count4", 64'(cnt[4]), 64'd10);
        check_got("rr_flits");

        // Contention: port 0 header waits while port 1 owns the link.
        set_port(1, 1'b1, 32'h50, 1'b1, 1'b0);
        tick();
        chk("cont_grant1", grant, 5'b00010);
        set_port(0, 1'b1, 32'h60, 1'b1, 1'b1);
        #1;
        chk("cont_ready_a", in_ready, 5'b00010);
        tick();
        set_port(1, 1'b1, 32'h51, 1'b0, 1'b0);
        #1;
        chk("cont_ready0_b", in_ready[0], 1'b0);
        tick();
        set_port(1, 1'b1, 32'h52, 1'b0, 1'b1);
        #1;
        chk("cont_ready0_c", in_ready[0], 1'b0);
        tick();
        set_port(1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("cont_dead_grant", grant, 5'b00000);
        chk("cont_dead_ready", in_ready, 5'b00000);
        tick();
        chk("cont_grant0", grant, 5'b00001);
        tick();
        clr();
        exp_q.push_back(32'h50);
        exp_q.push_back(32'h51);
        exp_q.push_back(32'h52);
        exp_q.push_back(32'h60);
        check_got("cont_flits");

        // Orphan body flit while idle, then reset in the middle of a packet.
        set_port(4, 1'b1, 32'h70, 1'b0, 1'b0);
        tick();
        chk("orphan_set", err_orphan, 1'b1);
        clr();
        tick();
        chk("orphan_sticky", err_orphan, 1'b1);
        chk("orphan_no_grant", grant, 5'b00000);
        set_port(4, 1'b1, 32'h71, 1'b1, 1'b0);
        tick();
        chk("midrst_grant", grant, 5'b10000);
        tick();
        set_port(4, 1'b1, 32'h72, 1'b0, 1'b0);
        out_ready = 1'b0;
        noc_rst   = 1'b1;
        tick();
        chk("midrst_grant0",  grant,      5'b00000);
        chk("midrst_valid",   out_valid,  1'b0);
        chk("midrst_orphan",  err_orphan, 1'b0);
        noc_rst   = 1'b0;
        out_ready = 1'b1;
        set_port(4, 1'b1, 32'h73, 1'b0, 1'b1);
        tick();
        chk("midrst_not_fwd", out_valid, 1'b0);
        chk("midrst_reorphan", err_orphan, 1'b1);
        clr();
        exp_q.push_back(32'h71);
        check_got("midrst_flits");

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
